// File: rtl/mem_arbiter_pkg.sv
// Shared port identifiers, lock-owner encodings and read-tag payload for mem_arbiter.
package mem_arbiter_pkg;

    localparam logic       PORT_A   = 1'b0;
    localparam logic       PORT_B   = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    // Tag carried alongside a read while it travels through the memory.
    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin picker: the lock owner takes the bus, otherwise the port that went last loses the tie.
module mem_arbiter_rr
    import mem_arbiter_pkg::*;
(
    input  logic       a_req,
    input  logic       b_req,
    input  logic       last_gnt,
    input  logic [1:0] lock_owner,
    output logic       a_gnt_c,
    output logic       b_gnt_c
);

    always_comb begin
        a_gnt_c = 1'b0;
        b_gnt_c = 1'b0;
        if (lock_owner == OWN_A) begin
            a_gnt_c = a_req;
        end else if (lock_owner == OWN_B) begin
            b_gnt_c = b_req;
        end else if (a_req && b_req) begin
            a_gnt_c = (last_gnt == PORT_B);
            b_gnt_c = (last_gnt == PORT_A);
        end else begin
            a_gnt_c = a_req;
            b_gnt_c = b_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the mem_wrapper bus between CPU (port A) and UART loader (port B), one access per cycle.
// Define MEM_ARB_LOCK_EN to enable bus locking with a LOCK_MAX consecutive-grant limit.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 8,
    parameter int unsigned LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [addr_width-1:0] a_addr,
    input  logic [data_width-1:0] a_din,
    input  logic                  a_mmio,
    input  logic                  a_lock,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [data_width-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [addr_width-1:0] b_addr,
    input  logic [data_width-1:0] b_din,
    input  logic                  b_mmio,
    input  logic                  b_lock,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [data_width-1:0] b_rdata,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_din,
    output logic                  mem_we,
    output logic                  mem_mmio,
    input  logic [data_width-1:0] mem_dout
);

    if (LOCK_MAX < 1) begin : g_lock_max_check
        $error("mem_arbiter: LOCK_MAX must be at least 1");
    end

    logic       last_gnt_q;
    logic [1:0] lock_owner_q;
    rd_tag_t    tag_q;
    logic       a_gnt_rr;
    logic       b_gnt_rr;
    logic       any_gnt;
    logic       sel_b;
    logic       sel_we;

    mem_arbiter_rr u_rr (
        .a_req      (a_req),
        .b_req      (b_req),
        .last_gnt   (last_gnt_q),
        .lock_owner (lock_owner_q),
        .a_gnt_c    (a_gnt_rr),
        .b_gnt_c    (b_gnt_rr)
    );

    // A grant during reset would be dropped by the register reset, so it is never offered.
    assign a_gnt   = a_gnt_rr & ~rst;
    assign b_gnt   = b_gnt_rr & ~rst;
    assign any_gnt = a_gnt | b_gnt;
    assign sel_b   = b_gnt;
    assign sel_we  = sel_b ? b_we : a_we;

    assign a_rdata = mem_dout;
    assign b_rdata = mem_dout;

    // Bus drive, round-robin history and the two-stage read tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_we     <= 1'b0;
            mem_mmio   <= 1'b0;
            last_gnt_q <= PORT_B;
            tag_q      <= '0;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
        end else begin
            mem_we <= any_gnt & sel_we;
            if (any_gnt) begin
                mem_addr   <= sel_b ? b_addr : a_addr;
                mem_din    <= sel_b ? b_din : a_din;
                mem_mmio   <= sel_b ? b_mmio : a_mmio;
                last_gnt_q <= sel_b ? PORT_B : PORT_A;
            end
            tag_q.valid <= any_gnt & ~sel_we;
            tag_q.port  <= sel_b ? PORT_B : PORT_A;
            a_rvalid    <= tag_q.valid & (tag_q.port == PORT_A);
            b_rvalid    <= tag_q.valid & (tag_q.port == PORT_B);
        end
    end

`ifdef MEM_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    logic [CNT_W-1:0] lock_cnt_q;
    logic [CNT_W-1:0] lock_cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       lock_owner_d;
    logic [1:0]       gnt_own;
    logic             gnt_lock;
    logic             owner_req;

    // Lock ownership: set by a locked grant, dropped on unlock, idle owner or LOCK_MAX grants.
    always_comb begin
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        gnt_own      = sel_b ? OWN_B : OWN_A;
        gnt_lock     = sel_b ? b_lock : a_lock;
        owner_req    = (lock_owner_q == OWN_A) ? a_req : b_req;
        if (lock_owner_q != gnt_own) begin
            cnt_inc = CNT_W'(1);
        end else if (lock_cnt_q == CNT_W'(LOCK_MAX)) begin
            cnt_inc = lock_cnt_q;
        end else begin
            cnt_inc = lock_cnt_q + CNT_W'(1);
        end

        if ((lock_owner_q != OWN_NONE) && !owner_req) begin
            lock_owner_d = OWN_NONE;
            lock_cnt_d   = '0;
        end else if (any_gnt) begin
            if (!gnt_lock || (cnt_inc >= CNT_W'(LOCK_MAX))) begin
                lock_owner_d = OWN_NONE;
                lock_cnt_d   = '0;
            end else begin
                lock_owner_d = gnt_own;
                lock_cnt_d   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_owner_q <= OWN_NONE;
            lock_cnt_q   <= '0;
        end else begin
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end
`else
    logic unused_lock;

    assign lock_owner_q = OWN_NONE;
    assign unused_lock  = &{1'b0, a_lock, b_lock};
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: bus-slave memory, per-cycle reference model, directed and random stimulus.
module tb_mem_arbiter;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 8;
    localparam int unsigned LMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, a_mmio = 1'b0, a_lock = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_din = '0;
    logic          b_req = 1'b0, b_we = 1'b0, b_mmio = 1'b0, b_lock = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_din = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic          mem_we, mem_mmio;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.data_width(DW), .addr_width(AW), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_mmio(a_mmio),
        .a_lock(a_lock), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_mmio(b_mmio),
        .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_mmio(mem_mmio),
        .mem_dout(mem_dout)
    );

    function automatic logic [7:0] init_val(input int i);
        return (i == 5) ? 8'h3C : 8'(i * 37 + 11);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // mem_wrapper stand-in: RAM0 with registered read, LED register at MMIO 0x10.
    logic [7:0] ram [256];
    logic [7:0] leds;
    logic [7:0] dout_q;
    initial begin
        for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        leds   <= 8'h00;
        dout_q <= 8'h00;
    end
    always @(posedge clk) begin
        if (mem_we && !mem_mmio) ram[mem_addr] <= mem_din;
        if (mem_we && mem_mmio && mem_addr == 8'h10) leds <= mem_din;
        dout_q <= mem_mmio ? leds : ram[mem_addr];
    end
    assign mem_dout = dout_q;

    // Reference model state: what the bus and read returns must look like.
    logic [7:0] shadow [256];
    logic [7:0] s_leds;
    bit         m_ok = 1'b0;
    int         m_last, m_owner, m_cnt, cyc = 0;
    logic [7:0] e_addr, e_din;
    logic       e_we, e_mmio;
    bit         rv_v [4];
    int         rv_p [4];
    logic [7:0] rv_d [4];
    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        s_leds = 8'h00;
    end

    bit         ea, eb, g_we, g_mmio, g_lock;
    int         gp, slot, nc;
    logic [7:0] g_addr, g_din;

    always @(negedge clk) begin
        cyc++;
        slot = cyc % 4;
        if (rst) begin
            m_ok = 1'b1;
            m_last = 1; m_owner = 0; m_cnt = 0;
            e_addr = 8'h00; e_din = 8'h00; e_we = 1'b0; e_mmio = 1'b0;
            for (int i = 0; i < 4; i++) rv_v[i] = 1'b0;
        end else if (m_ok) begin
            ea = 1'b0; eb = 1'b0;
            if (m_owner == 1) ea = a_req;
            else if (m_owner == 2) eb = b_req;
            else if (a_req && b_req) begin ea = (m_last == 1); eb = (m_last == 0); end
            else begin ea = a_req; eb = b_req; end
            chk("a_gnt", 32'(a_gnt), 32'(ea));
            chk("b_gnt", 32'(b_gnt), 32'(eb));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_din", 32'(mem_din), 32'(e_din));
            chk("mem_mmio", 32'(mem_mmio), 32'(e_mmio));
            chk("a_rvalid", 32'(a_rvalid), 32'(rv_v[slot] && rv_p[slot] == 0));
            chk("b_rvalid", 32'(b_rvalid), 32'(rv_v[slot] && rv_p[slot] == 1));
            if (rv_v[slot]) chk("rdata", 32'(rv_p[slot] == 0 ? a_rdata : b_rdata), 32'(rv_d[slot]));
            rv_v[slot] = 1'b0;

            e_we = 1'b0;
            if (ea || eb) begin
                gp     = eb ? 1 : 0;
                g_we   = eb ? b_we : a_we;
                g_mmio = eb ? b_mmio : a_mmio;
                g_lock = eb ? b_lock : a_lock;
                g_addr = eb ? b_addr : a_addr;
                g_din  = eb ? b_din : a_din;
                e_we = g_we; e_addr = g_addr; e_din = g_din; e_mmio = g_mmio;
                if (g_we) begin
                    if (!g_mmio) shadow[g_addr] = g_din;
                    else if (g_addr == 8'h10) s_leds = g_din;
                end else begin
                    rv_v[(cyc + 2) % 4] = 1'b1;
                    rv_p[(cyc + 2) % 4] = gp;
                    rv_d[(cyc + 2) % 4] = g_mmio ? s_leds : shadow[g_addr];
                end
                m_last = gp;
            end
`ifdef MEM_ARB_LOCK_EN
            if (m_owner != 0 && !(m_owner == 1 ? a_req : b_req)) begin
                m_owner = 0; m_cnt = 0;
            end else if (ea || eb) begin
                nc = (m_owner == gp + 1) ? m_cnt + 1 : 1;
                if (!g_lock || nc >= int'(LMAX)) begin m_owner = 0; m_cnt = 0; end
                else begin m_owner = gp + 1; m_cnt = nc; end
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic rnd_port(output logic req, output logic we, output logic mmio,
                            output logic lock, output logic [7:0] addr, output logic [7:0] din);
        req  = ($urandom_range(0, 3) != 0);
        we   = $urandom_range(0, 1) == 1;
        mmio = ($urandom_range(0, 3) == 0);
        lock = ($urandom_range(0, 2) != 0);
        addr = mmio ? 8'h10 : 8'($urandom_range(0, 15));
        din  = 8'($urandom);
    endtask

    logic [5:0] seq;
    logic       ga, gb;

    initial begin
        // Single read from A: grant now, bus next cycle, data two cycles after grant.
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h05; a_mmio = 1'b0;
        @(negedge clk); chk("t1_a_gnt", 32'(a_gnt), 32'd1); chk("t1_b_gnt", 32'(b_gnt), 32'd0);
        tick(); a_req = 1'b0;
        @(negedge clk); chk("t1_mem_addr", 32'(mem_addr), 32'h05); chk("t1_mem_we", 32'(mem_we), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_a_rvalid", 32'(a_rvalid), 32'd1);
        chk("t1_a_rdata", 32'(a_rdata), 32'h3C);
        chk("t1_b_rvalid", 32'(b_rvalid), 32'd0);

        // Both ports held: strict alternation starting with A.
        do_reset();
        a_req = 1'b1; a_addr = 8'h01; a_we = 1'b0;
        b_req = 1'b1; b_addr = 8'h02; b_we = 1'b0; b_mmio = 1'b0;
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seq = {seq[4:0], b_gnt};
            chk("t2_one_gnt", 32'(a_gnt ^ b_gnt), 32'd1);
            tick();
        end
        chk("t2_sequence", 32'(seq), 32'(6'b010101));

        // Same with a_lock held: lock limit forces one B grant after LMAX A grants.
        do_reset();
        a_req = 1'b1; b_req = 1'b1; a_lock = 1'b1;
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seq = {seq[4:0], b_gnt};
            tick();
        end
`ifdef MEM_ARB_LOCK_EN
        chk("t2_lock_sequence", 32'(seq), 32'(6'b000010));
`else
        chk("t2_lock_sequence", 32'(seq), 32'(6'b010101));
`endif
        a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0;
        tick(); tick();

        // B writes the LED register, followed by an idle cycle.
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'h10; b_din = 8'hA5; b_mmio = 1'b1;
        @(negedge clk); chk("t3_b_gnt", 32'(b_gnt), 32'd1);
        tick(); b_req = 1'b0;
        @(negedge clk);
        chk("t3_mem_we", 32'(mem_we), 32'd1);
        chk("t3_mem_mmio", 32'(mem_mmio), 32'd1);
        chk("t3_mem_addr", 32'(mem_addr), 32'h10);
        chk("t3_mem_din", 32'(mem_din), 32'hA5);
        tick();
        @(negedge clk);
        chk("t3_idle_we", 32'(mem_we), 32'd0);
        chk("t3_idle_addr", 32'(mem_addr), 32'h10);
        chk("t3_leds", 32'(leds), 32'hA5);
        chk("t3_b_rvalid", 32'(b_rvalid), 32'd0);
        tick();
        @(negedge clk); chk("t3_b_rvalid2", 32'(b_rvalid), 32'd0);

        // Reset the cycle after a read grant drops the read.
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h07; a_din = 8'h5A; a_mmio = 1'b0;
        @(negedge clk); chk("t4_a_gnt", 32'(a_gnt), 32'd1);
        tick(); a_req = 1'b0; rst = 1'b1;
        @(negedge clk); chk("t4_mem_din_pre", 32'(mem_din), 32'h5A);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("t4_mem_addr", 32'(mem_addr), 32'h00);
        chk("t4_mem_din", 32'(mem_din), 32'h00);
        chk("t4_mem_we", 32'(mem_we), 32'd0);
        chk("t4_a_rvalid", 32'(a_rvalid), 32'd0);
        tick();
        @(negedge clk); chk("t4_a_rvalid2", 32'(a_rvalid), 32'd0);

        // Random traffic; an ungranted request is held stable until granted.
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            ga = a_gnt; gb = b_gnt;
            tick();
            rst = ($urandom_range(0, 59) == 0);
            if (!a_req || ga) rnd_port(a_req, a_we, a_mmio, a_lock, a_addr, a_din);
            if (!b_req || gb) rnd_port(b_req, b_we, b_mmio, b_lock, b_addr, b_din);
        end
        rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
